// File: rtl/recepcao_pixels_serial_if.sv
// recepcao_pixels_serial_if: pixel write bus towards the image RAM
interface recepcao_pixels_serial_if #(
  parameter int S_DATA   = 16,
  parameter int S_LINE   = 7,
  parameter int S_COLUMN = 9
);
  logic [S_DATA-1:0]   pixel;
  logic [S_LINE-1:0]   linha;
  logic [S_COLUMN-1:0] coluna;
  logic                we_pixel;
  modport master (output pixel, linha, coluna, we_pixel);
  modport slave  (input  pixel, linha, coluna, we_pixel);
endinterface

// File: rtl/recepcao_pixels_serial.sv
// recepcao_pixels_serial: UART 8N1 receiver pairing bytes into RGB565 pixels with RAM write addresses.
// Define RECEPCAO_PARIDADE_EN for 8E1 frames and the erro_paridade output.
module recepcao_pixels_serial #(
  parameter int CLKS_PER_BIT = 434,
  parameter int LINES        = 120,
  parameter int COLUMNS      = 320,
  parameter int S_DATA       = 16,
  parameter int S_LINE       = 7,
  parameter int S_COLUMN     = 9
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            iniciar,
  input  logic                            rx_serial,
  recepcao_pixels_serial_if.master        wr,
  output logic                            fim_recepcao,
  output logic                            erro_quadro,
  output logic [3:0]                      db_estado
`ifdef RECEPCAO_PARIDADE_EN
  ,
  output logic                            erro_paridade
`endif
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST    = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    U_IDLE, U_START, U_DATA,
`ifdef RECEPCAO_PARIDADE_EN
    U_PAR,
`endif
    U_STOP
  } uart_t;

  typedef enum logic [2:0] {
    OCIOSO       = 3'd0,
    RECEBE_ALTO  = 3'd1,
    RECEBE_BAIXO = 3'd2,
    ESCREVE      = 3'd3,
    FIM          = 3'd4
  } frame_t;

  uart_t          u_st;
  frame_t         st;
  logic           rx_s1, rx_s2, rx_prev;
  logic [CW-1:0]  cnt;
  logic [2:0]     idx;
  logic [7:0]     shreg;
  logic           byte_valid, frame_err;
  logic           last_col, last_line;
`ifdef RECEPCAO_PARIDADE_EN
  logic           par_bad, par_err;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_prev    <= 1'b1;
      u_st       <= U_IDLE;
      cnt        <= '0;
      idx        <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef RECEPCAO_PARIDADE_EN
      par_bad    <= 1'b0;
      par_err    <= 1'b0;
`endif
    end else begin
      rx_s1      <= rx_serial;
      rx_s2      <= rx_s1;
      rx_prev    <= rx_s2;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef RECEPCAO_PARIDADE_EN
      par_err    <= 1'b0;
`endif
      cnt        <= cnt + 1'b1;
      case (u_st)
        U_IDLE: begin
          cnt <= '0;
          if (rx_prev && !rx_s2) u_st <= U_START;
        end
        U_START: if (cnt == HALF_M1) begin
          cnt  <= '0;
          idx  <= '0;
          u_st <= rx_s2 ? U_IDLE : U_DATA;
        end
        U_DATA: if (cnt == LAST) begin
          cnt   <= '0;
          shreg <= {rx_s2, shreg[7:1]};
          idx   <= idx + 1'b1;
`ifdef RECEPCAO_PARIDADE_EN
          if (idx == 3'd7) u_st <= U_PAR;
`else
          if (idx == 3'd7) u_st <= U_STOP;
`endif
        end
`ifdef RECEPCAO_PARIDADE_EN
        U_PAR: if (cnt == LAST) begin
          cnt     <= '0;
          par_bad <= (^shreg) ^ rx_s2;
          u_st    <= U_STOP;
        end
        U_STOP: if (cnt == LAST) begin
          u_st       <= U_IDLE;
          byte_valid <= rx_s2 && !par_bad;
          par_err    <= rx_s2 && par_bad;
          frame_err  <= !rx_s2;
        end
`else
        U_STOP: if (cnt == LAST) begin
          u_st       <= U_IDLE;
          byte_valid <= rx_s2;
          frame_err  <= !rx_s2;
        end
`endif
        default: u_st <= U_IDLE;
      endcase
    end
  end

  assign last_col  = wr.coluna == S_COLUMN'(COLUMNS - 1);
  assign last_line = wr.linha  == S_LINE'(LINES - 1);
  assign db_estado = {1'b0, st};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st           <= OCIOSO;
      wr.pixel     <= '0;
      wr.linha     <= '0;
      wr.coluna    <= '0;
      wr.we_pixel  <= 1'b0;
      fim_recepcao <= 1'b0;
      erro_quadro  <= 1'b0;
`ifdef RECEPCAO_PARIDADE_EN
      erro_paridade <= 1'b0;
`endif
    end else if (iniciar) begin
      st           <= RECEBE_ALTO;
      wr.linha     <= '0;
      wr.coluna    <= '0;
      wr.we_pixel  <= 1'b0;
      fim_recepcao <= 1'b0;
      erro_quadro  <= 1'b0;
`ifdef RECEPCAO_PARIDADE_EN
      erro_paridade <= 1'b0;
`endif
    end else begin
      wr.we_pixel <= 1'b0;
      if (frame_err) erro_quadro <= 1'b1;
`ifdef RECEPCAO_PARIDADE_EN
      if (par_err) erro_paridade <= 1'b1;
`endif
      case (st)
        RECEBE_ALTO: if (byte_valid) begin
          wr.pixel[S_DATA-1 -: 8] <= shreg;
          st <= RECEBE_BAIXO;
        end
        RECEBE_BAIXO: if (byte_valid) begin
          wr.pixel[7:0] <= shreg;
          wr.we_pixel   <= 1'b1;
          st            <= ESCREVE;
        end
        ESCREVE: begin
          wr.coluna    <= last_col ? '0 : wr.coluna + 1'b1;
          wr.linha     <= !last_col ? wr.linha : (last_line ? '0 : wr.linha + 1'b1);
          st           <= (last_col && last_line) ? FIM : RECEBE_ALTO;
          fim_recepcao <= last_col && last_line;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_recepcao_pixels_serial.sv
// tb_recepcao_pixels_serial: directed UART frames with a scoreboard of expected pixel writes.
module tb_recepcao_pixels_serial;
  localparam int CPB = 8;
  localparam int LINES = 2;
  localparam int COLUMNS = 3;
  localparam int S_DATA = 16;
  localparam int S_LINE = 1;
  localparam int S_COLUMN = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic iniciar = 1'b0;
  logic rx = 1'b1;
  logic fim_recepcao, erro_quadro;
  logic [3:0] db_estado;
`ifdef RECEPCAO_PARIDADE_EN
  logic erro_paridade;
`endif

  int errors = 0;
  int checks = 0;
  int wr_count = 0;
  int w0;
  logic [18:0] exp_q[$];

  recepcao_pixels_serial_if #(.S_DATA(S_DATA), .S_LINE(S_LINE), .S_COLUMN(S_COLUMN)) wr ();

  recepcao_pixels_serial #(
    .CLKS_PER_BIT(CPB), .LINES(LINES), .COLUMNS(COLUMNS),
    .S_DATA(S_DATA), .S_LINE(S_LINE), .S_COLUMN(S_COLUMN)
  ) dut (
    .clock(clk),
    .reset(rst_n),
    .iniciar(iniciar),
    .rx_serial(rx),
    .wr(wr),
    .fim_recepcao(fim_recepcao),
    .erro_quadro(erro_quadro),
    .db_estado(db_estado)
`ifdef RECEPCAO_PARIDADE_EN
    ,
    .erro_paridade(erro_paridade)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [18:0] pk(input logic [15:0] p, input int l, input int c);
    return {p, 1'(l), 2'(c)};
  endfunction

  always @(negedge clk) begin
    if (wr.we_pixel === 1'b1) begin
      wr_count++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got %0h expected none", {wr.pixel, wr.linha, wr.coluna});
      end else begin
        chk("write", 32'({wr.pixel, wr.linha, wr.coluna}), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic bit_time();
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
    rx = 1'b0;
    bit_time();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      bit_time();
    end
`ifdef RECEPCAO_PARIDADE_EN
    rx = ^b;
    bit_time();
`endif
    rx = stop_bit;
    bit_time();
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
  endtask

  task automatic pulse_iniciar();
    @(negedge clk);
    iniciar = 1'b1;
    @(negedge clk);
    iniciar = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_pixel", 32'(wr.pixel), 0);
    chk("rst_addr", 32'({wr.linha, wr.coluna}), 0);
    chk("rst_we", 32'(wr.we_pixel), 0);
    chk("rst_fim", 32'(fim_recepcao), 0);
    chk("rst_erro", 32'(erro_quadro), 0);
    chk("rst_estado", 32'(db_estado), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    w0 = wr_count;
    send_byte(8'hA5);
    send_byte(8'h3C);
    chk("idle_writes", 32'(wr_count - w0), 0);
    chk("idle_estado", 32'(db_estado), 0);

    pulse_iniciar();
    chk("arm_estado", 32'(db_estado), 1);
    w0 = wr_count;
    exp_q.push_back(pk(16'h1234, 0, 0));
    send_byte(8'h12);
    chk("half_estado", 32'(db_estado), 2);
    send_byte(8'h34);
    chk("one_writes", 32'(wr_count - w0), 1);
    chk("one_coluna", 32'(wr.coluna), 1);
    chk("one_linha", 32'(wr.linha), 0);
    chk("one_estado", 32'(db_estado), 1);

    pulse_iniciar();
    chk("rearm_coluna", 32'(wr.coluna), 0);
    w0 = wr_count;
    for (int i = 0; i < 6; i++)
      exp_q.push_back(pk({8'(2 * i), 8'(2 * i + 1)}, i / COLUMNS, i % COLUMNS));
    for (int i = 0; i < 12; i++) send_byte(8'(i));
    chk("frame_writes", 32'(wr_count - w0), 6);
    chk("frame_fim", 32'(fim_recepcao), 1);
    chk("frame_estado", 32'(db_estado), 4);
    chk("frame_addr", 32'({wr.linha, wr.coluna}), 0);
    chk("frame_last_pixel", 32'(wr.pixel), 32'h0A0B);
    w0 = wr_count;
    send_byte(8'hFF);
    chk("fim_no_write", 32'(wr_count - w0), 0);
    chk("fim_hold", 32'(fim_recepcao), 1);

    pulse_iniciar();
    chk("restart_fim", 32'(fim_recepcao), 0);
    chk("restart_estado", 32'(db_estado), 1);
    w0 = wr_count;
    send_byte(8'h55, 1'b0);
    chk("ferr_flag", 32'(erro_quadro), 1);
    chk("ferr_estado", 32'(db_estado), 1);
    exp_q.push_back(pk(16'h1234, 0, 0));
    send_byte(8'h12);
    send_byte(8'h34);
    chk("ferr_sticky", 32'(erro_quadro), 1);
    chk("ferr_writes", 32'(wr_count - w0), 1);

    w0 = wr_count;
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    chk("glitch_estado", 32'(db_estado), 1);
    chk("glitch_writes", 32'(wr_count - w0), 0);
    send_byte(8'h12);
    chk("glitch_then_byte", 32'(db_estado), 2);
    pulse_iniciar();
    chk("mid_restart_estado", 32'(db_estado), 1);
    chk("mid_restart_erro", 32'(erro_quadro), 0);
    exp_q.push_back(pk(16'h3456, 0, 0));
    send_byte(8'h34);
    send_byte(8'h56);
    chk("mid_restart_writes", 32'(wr_count - w0), 1);
    chk("mid_restart_coluna", 32'(wr.coluna), 1);

    rx = 1'b0;
    bit_time();
    rx = 1'b1;
    repeat (12) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_pixel", 32'(wr.pixel), 0);
    chk("async_addr", 32'({wr.linha, wr.coluna}), 0);
    chk("async_estado", 32'(db_estado), 0);
    @(negedge clk);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    pulse_iniciar();
    w0 = wr_count;
    exp_q.push_back(pk(16'hC3A5, 0, 0));
    send_byte(8'hC3);
    send_byte(8'hA5);
    chk("post_reset_writes", 32'(wr_count - w0), 1);

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
